// File: rtl/sync_ram_pkg.sv
// Shared encodings and limits for the simple-dual-port synchronous RAM.
package sync_ram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } ram_state_e;

   localparam int RDW_READ_FIRST   = 0;
   localparam int RDW_WRITE_FIRST  = 1;
   localparam int MAX_READ_LATENCY = 4;

endpackage

// File: rtl/ram_rd_pipe.sv
// Delay line for read responses placed after the registered array read.
// Stages only load on a valid so the output holds its last response.
module ram_rd_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int STAGES     = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_err,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_err
);

   if (STAGES == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clock, reset};
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign out_err   = in_err;
   end else begin : g_stages
      logic [STAGES-1:0]     v;
      logic [STAGES-1:0]     e;
      logic [DATA_WIDTH-1:0] d [STAGES];

      // Only the output stage needs a data reset: it defines rsp_data/rsp_err.
      always_ff @(posedge clock) begin
         if (reset) begin
            v            <= '0;
            d[STAGES-1]  <= '0;
            e[STAGES-1]  <= 1'b0;
         end else begin
            v[0] <= in_valid;
            if (in_valid) begin
               d[0] <= in_data;
               e[0] <= in_err;
            end
            for (int i = 1; i < STAGES; i++) begin
               v[i] <= v[i-1];
               if (v[i-1]) begin
                  d[i] <= d[i-1];
                  e[i] <= e[i-1];
               end
            end
         end
      end

      assign out_valid = v[STAGES-1];
      assign out_data  = d[STAGES-1];
      assign out_err   = e[STAGES-1];
   end

endmodule

// File: rtl/sync_ram_dp.sv
// Simple-dual-port synchronous RAM with byte enables, clear-on-reset and
// pipelined reads.
//
//   state    | meaning
//   ST_CLEAR | zeroing words 0..DEPTH-1, one per cycle; ports blocked
//   ST_READY | normal write/read traffic accepted
module sync_ram_dp
   import sync_ram_pkg::*;
#(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH          = 256,
   parameter int READ_LATENCY   = 1,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic                    ready,
   input  logic                    wr_valid,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    rd_valid,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic                    rsp_err
);

   localparam int                  BYTES     = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] DEPTH_X   = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
      $fatal(1, "sync_ram_dp: DATA_WIDTH must be a non-zero multiple of 8");
   end
   if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
      $fatal(1, "sync_ram_dp: DEPTH must be in 1..2**ADDR_WIDTH");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_lat
      $fatal(1, "sync_ram_dp: READ_LATENCY must be in 1..4");
   end

   ram_state_e            state, state_nxt;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  clearing;
   logic                  wr_in_rng, rd_in_rng;
   logic                  wr_acc, rd_acc, collide;
   logic [DATA_WIDTH-1:0] old_word, merged, rd_word;
   logic                  s1_valid, s1_err;
   logic [DATA_WIDTH-1:0] s1_data;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         if (CLEAR_ON_RESET != 0) state <= ST_CLEAR;
         else                     state <= ST_READY;
         clr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_CLEAR) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR: if (clr_cnt == LAST_ADDR) state_nxt = ST_READY;
         ST_READY: state_nxt = ST_READY;
         default:  state_nxt = state;
      endcase
   end

   // Gated by reset so nothing is accepted in a reset cycle.
   assign ready     = (state == ST_READY) & ~reset;
   assign clearing  = (state == ST_CLEAR) & ~reset;

   assign wr_in_rng = {1'b0, wr_addr} < DEPTH_X;
   assign rd_in_rng = {1'b0, rd_addr} < DEPTH_X;
   assign wr_acc    = wr_valid & ready & wr_in_rng;
   assign rd_acc    = rd_valid & ready;
   assign collide   = wr_acc & rd_in_rng & (wr_addr == rd_addr);

   always_ff @(posedge clock) begin
      if (clearing) begin
         mem[clr_cnt] <= '0;
      end else if (wr_acc) begin
         for (int b = 0; b < BYTES; b++) begin
            if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   assign old_word = mem[rd_addr];

   always_comb begin
      merged = old_word;
      for (int b = 0; b < BYTES; b++) begin
         if (wr_be[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
      end
   end

   assign rd_word = (RDW_MODE == RDW_WRITE_FIRST && collide) ? merged : old_word;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_err   <= 1'b0;
      end else begin
         s1_valid <= rd_acc;
         if (rd_acc) begin
            s1_err  <= ~rd_in_rng;
            s1_data <= rd_in_rng ? rd_word : '0;
         end
      end
   end

   ram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGES     (READ_LATENCY - 1)
   ) u_rd_pipe (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (s1_valid),
      .in_data   (s1_data),
      .in_err    (s1_err),
      .out_valid (rsp_valid),
      .out_data  (rsp_data),
      .out_err   (rsp_err)
   );

endmodule

// File: tb/tb_sync_ram_dp.sv
// Directed bench: three RAM configurations share one clock, reset and request bus.
module tb_sync_ram_dp;

   logic        clock;
   logic        reset;
   logic        wr_valid, rd_valid, c_wr_valid, c_rd_valid;
   logic [7:0]  wr_addr, rd_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;

   logic        ready_a, rsp_valid_a, rsp_err_a;
   logic [31:0] rsp_data_a;
   logic        ready_b, rsp_valid_b, rsp_err_b;
   logic [31:0] rsp_data_b;
   logic        ready_c, rsp_valid_c, rsp_err_c;
   logic [31:0] rsp_data_c;

   int n_chk  = 0;
   int n_fail = 0;

   // a: defaults (256 words, latency 1, read-first, clear on reset)
   sync_ram_dp u_a (
      .clock(clock), .reset(reset), .ready(ready_a),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_valid(rd_valid), .rd_addr(rd_addr),
      .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .rsp_err(rsp_err_a)
   );

   // b: 200 words, latency 3, write-first
   sync_ram_dp #(.DEPTH(200), .READ_LATENCY(3), .RDW_MODE(1)) u_b (
      .clock(clock), .reset(reset), .ready(ready_b),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_valid(rd_valid), .rd_addr(rd_addr),
      .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b)
   );

   // c: no clear, full 16-word address space, latency 2
   sync_ram_dp #(.ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(0)) u_c (
      .clock(clock), .reset(reset), .ready(ready_c),
      .wr_valid(c_wr_valid), .wr_addr(wr_addr[3:0]), .wr_data(wr_data), .wr_be(wr_be),
      .rd_valid(c_rd_valid), .rd_addr(rd_addr[3:0]),
      .rsp_valid(rsp_valid_c), .rsp_data(rsp_data_c), .rsp_err(rsp_err_c)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a);
      rd_valid = 1'b1; rd_addr = a;
      tick();
      rd_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      wr_valid = 1'b0; rd_valid = 1'b0; c_wr_valid = 1'b0; c_rd_valid = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
      repeat (3) tick();

      chk("reset_ready_a", {31'd0, ready_a}, 32'd0);
      chk("reset_rsp_valid_a", {31'd0, rsp_valid_a}, 32'd0);
      chk("reset_rsp_data_a", rsp_data_a, 32'd0);
      chk("reset_rsp_err_a", {31'd0, rsp_err_a}, 32'd0);
      chk("reset_rsp_data_b", rsp_data_b, 32'd0);
      chk("reset_ready_c", {31'd0, ready_c}, 32'd0);

      // 1: clear timing
      reset = 1'b0;
      #1;
      chk("noclear_ready_c", {31'd0, ready_c}, 32'd1);
      chk("clear_ready_a_start", {31'd0, ready_a}, 32'd0);
      for (int i = 1; i <= 256; i++) begin
         tick();
         if (i == 199) chk("clear_ready_b_199", {31'd0, ready_b}, 32'd0);
         if (i == 200) chk("clear_ready_b_200", {31'd0, ready_b}, 32'd1);
         if (i == 255) chk("clear_ready_a_255", {31'd0, ready_a}, 32'd0);
         if (i == 256) chk("clear_ready_a_256", {31'd0, ready_a}, 32'd1);
      end
      rd(8'd0);
      chk("clr_rd0_valid", {31'd0, rsp_valid_a}, 32'd1);
      chk("clr_rd0_data", rsp_data_a, 32'd0);
      rd(8'd128);
      chk("clr_rd128_data", rsp_data_a, 32'd0);
      rd(8'd255);
      chk("clr_rd255_data", rsp_data_a, 32'd0);
      chk("clr_rd255_err", {31'd0, rsp_err_a}, 32'd0);
      tick();
      chk("rsp_valid_pulse_a", {31'd0, rsp_valid_a}, 32'd0);
      tick();

      // 2: byte enables
      wr(8'd5, 32'h11223344, 4'hF);
      wr(8'd5, 32'hAABBCCDD, 4'b0101);
      rd(8'd5);
      chk("be_merge", rsp_data_a, 32'h11BB33DD);
      wr(8'd5, 32'hFFFFFFFF, 4'h0);
      rd(8'd5);
      chk("be_zero_noop", rsp_data_a, 32'h11BB33DD);
      repeat (3) tick();

      // 3: latency 3 throughput on b
      for (int i = 0; i < 10; i++) wr(8'(i), 32'(i * 3), 4'hF);
      for (int t = 1; t <= 14; t++) begin
         if (t <= 10) begin
            rd_valid = 1'b1;
            rd_addr  = 8'(t - 1);
         end else begin
            rd_valid = 1'b0;
         end
         tick();
         chk($sformatf("lat3_valid_t%0d", t), {31'd0, rsp_valid_b},
             (t >= 3 && t <= 12) ? 32'd1 : 32'd0);
         if (t >= 3 && t <= 12)
            chk($sformatf("lat3_data_t%0d", t), rsp_data_b, 32'((t - 3) * 3));
      end

      // 4: collisions
      wr(8'd7, 32'h0, 4'hF);
      wr_valid = 1'b1; wr_addr = 8'd7; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
      rd_valid = 1'b1; rd_addr = 8'd7;
      tick();
      wr_valid = 1'b0;
      chk("rdw_old_a", rsp_data_a, 32'h00000000);
      rd_addr = 8'd7;
      tick();
      rd_valid = 1'b0;
      chk("rdw_next_a", rsp_data_a, 32'hDEADBEEF);
      tick();
      chk("rdw_new_b_valid", {31'd0, rsp_valid_b}, 32'd1);
      chk("rdw_new_b", rsp_data_b, 32'hDEADBEEF);
      tick();
      chk("rdw_next_b", rsp_data_b, 32'hDEADBEEF);

      // partial-enable collision at addr 8 (holds 0x18)
      wr_valid = 1'b1; wr_addr = 8'd8; wr_data = 32'hA5A5A5A5; wr_be = 4'b0011;
      rd_valid = 1'b1; rd_addr = 8'd8;
      tick();
      wr_valid = 1'b0; rd_valid = 1'b0;
      chk("rdw_part_old_a", rsp_data_a, 32'h00000018);
      tick(); tick();
      chk("rdw_part_new_b", rsp_data_b, 32'h0000A5A5);
      tick();

      // 5: out of range on b (DEPTH 200)
      wr(8'd210, 32'h5A5A5A5A, 4'hF);
      rd(8'd210);
      tick(); tick();
      chk("oor_valid_b", {31'd0, rsp_valid_b}, 32'd1);
      chk("oor_err_b", {31'd0, rsp_err_b}, 32'd1);
      chk("oor_data_b", rsp_data_b, 32'd0);
      chk("inr_210_a", rsp_data_a, 32'h5A5A5A5A);
      tick();
      chk("hold_valid_b", {31'd0, rsp_valid_b}, 32'd0);
      chk("hold_err_b", {31'd0, rsp_err_b}, 32'd1);
      rd(8'd199);
      tick(); tick();
      chk("inr_199_err_b", {31'd0, rsp_err_b}, 32'd0);
      chk("inr_199_data_b", rsp_data_b, 32'd0);

      // c: full address range, latency 2, no clear
      c_wr_valid = 1'b1; wr_addr = 8'd3; wr_data = 32'h01020304; wr_be = 4'hF;
      tick();
      c_wr_valid = 1'b0;
      c_rd_valid = 1'b1; rd_addr = 8'd3;
      tick();
      c_rd_valid = 1'b0;
      chk("c_lat_not_yet", {31'd0, rsp_valid_c}, 32'd0);
      tick();
      chk("c_valid", {31'd0, rsp_valid_c}, 32'd1);
      chk("c_data", rsp_data_c, 32'h01020304);
      c_rd_valid = 1'b1; rd_addr = 8'd15;
      tick();
      c_rd_valid = 1'b0;
      tick();
      chk("c_top_addr_err", {31'd0, rsp_err_c}, 32'd0);
      tick();

      // 6: reset one cycle before the first response of b is due
      rd(8'd1);
      rd(8'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("rst_drop_valid_b", {31'd0, rsp_valid_b}, 32'd0);
      chk("rst_data_b", rsp_data_b, 32'd0);
      chk("rst_ready_a", {31'd0, ready_a}, 32'd0);
      for (int i = 1; i <= 256; i++) begin
         tick();
         if (i <= 4) chk($sformatf("rst_no_rsp_b_%0d", i), {31'd0, rsp_valid_b}, 32'd0);
         if (i == 199) chk("reclr_ready_b_199", {31'd0, ready_b}, 32'd0);
         if (i == 200) chk("reclr_ready_b_200", {31'd0, ready_b}, 32'd1);
         if (i == 255) chk("reclr_ready_a_255", {31'd0, ready_a}, 32'd0);
         if (i == 256) chk("reclr_ready_a_256", {31'd0, ready_a}, 32'd1);
      end
      rd(8'd5);
      chk("reclr_rd5_a", rsp_data_a, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
